multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM that sequences the RV32I datapath as a multi-cycle machine: one instruction spans 3-5 clock cycles.
- Decodes op, funct3 and funct7b5 from the instruction register.
- Drives all datapath enables, mux selects and ALUControl.
- Sits beside the datapath and the unified instruction/data memory; replaces the single-cycle combinational control path.

Parameters:
- STATE_W, 4, width of the state register and the dbg_state port.
- RESET_STATE, 0, encoding of FETCH, the state entered on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  7  Instr[6:0]
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register load enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  output  2  SrcB select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register file write enable
- dbg_state  output  STATE_W  current state

Behaviour:
- Reset and clocking:
  - Only clk is used. If reset is high at a rising edge, state <= FETCH (0). Reset overrides any in-flight instruction: no write completes after that edge.
  - Outputs are combinational (Moore) from the state, except ImmSrc, ALUControl and PCWrite, which also depend on op, funct3, funct7b5 and Zero.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ERROR=11.
- Outputs in FETCH (the state held from reset until the first post-reset edge):
  - AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1.
  - All other strobes are 0.
- Per-state outputs:
  - DECODE: ALUSrcA=01, ALUSrcB=01, add. Computes the branch/jump target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU decode.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU decode.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=Zero.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - ERROR: all strobes 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH (see optional feature)
  - MEMADR: op=0000011 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - ERROR: holds until reset.
  - Unused encodings (12-15) -> FETCH.
- Instruction latency: lw 5 cycles; sw, R-type, I-ALU, jal 4 cycles; beq 3 cycles.
- ALU decode (EXECUTER and EXECUTEI only), by funct3:
  - 000: sub if the state is EXECUTER and funct7b5=1, else add.
  - 010: slt. 110: or. 111: and.
  - Others: add.
- ImmSrc, decoded from op in every state:
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.
- Mutual exclusion: MemWrite, RegWrite and IRWrite are never high in the same cycle.

Optional Feature:
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - An unsupported op in DECODE goes to ERROR.
  - An extra output port illegal (1 bit) is 1 exactly in ERROR; its reset value is 0.
  - Only reset exits ERROR.
- Undefined: an unsupported op returns to FETCH and executes as a no-op; the illegal port does not exist.

Test Plan:
- Reset high 2 cycles, then low -> dbg_state=0, IRWrite=1, PCWrite=1, RegWrite=0, MemWrite=0.
- op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, ResultSrc=01 there.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in state 6; state 8 RegWrite=1; total 4 cycles.
- op=1100011, Zero=1 then Zero=0 on a second beq -> PCWrite=1 in state 9 for the first only; ImmSrc=10; ALUControl=001.
- op=0100011 with reset asserted while in state 5 -> MemWrite drops the next cycle, state=0, no RegWrite pulse.
- op=1111111 -> back to FETCH after DECODE without macro; with MC_CTRL_ILLEGAL_TRAP_EN, state=11, illegal=1 held until reset.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle control FSM (3-5 cycles per instruction)
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unsupported ops trap to ERROR and drive the illegal port.
module multicycle_controller #(
  parameter int STATE_W     = 4,
  parameter int RESET_STATE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic               illegal,
`endif
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state;
  state_t     state_next;
  logic [2:0] alu_dec;

  always_ff @(posedge clk) begin
    if (reset) state <= state_t'(RESET_STATE[3:0]);
    else       state <= state_next;
  end

  // The funct7b5 subtract bit only applies to R-type; in I-type it is immediate data.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (state == EXECUTER && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_next = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    case (state)
      FETCH: begin
        state_next = DECODE;
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_IALU:           state_next = EXECUTEI;
          OP_BEQ:            state_next = BEQ;
          OP_JAL:            state_next = JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           state_next = ERROR;
`else
          default:           state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_next = ALUWB;
      end
      ALUWB: RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = ALUWB;
      end
      ERROR:   state_next = ERROR;
      default: state_next = FETCH;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == ERROR);
`endif
  assign dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - random instruction stream against a spec-level control model
// Build with MC_CTRL_ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] dbg_state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int compared = 0;
  int mismatched = 0;
  int path_q[$];

  multicycle_controller #(.STATE_W(4), .RESET_STATE(0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Instruction walk through the state numbers, taken straight from the latency table.
  function automatic void build_path(input logic [6:0] o);
    path_q = {0, 1};
    case (o)
      7'b0000011: path_q = {path_q, 2, 3, 4};
      7'b0100011: path_q = {path_q, 2, 5};
      7'b0110011: path_q = {path_q, 6, 8};
      7'b0010011: path_q = {path_q, 7, 8};
      7'b1100011: path_q = {path_q, 9};
      7'b1101111: path_q = {path_q, 10, 8};
      default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        path_q = {path_q, 11};
`endif
      end
    endcase
  endfunction

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite}
  function automatic logic [15:0] exp_out(input int st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm = 0;
    logic [2:0] alu = 0, dec;
    dec = (f3 == 3'b010) ? 3'b101 : (f3 == 3'b110) ? 3'b011 : (f3 == 3'b111) ? 3'b010 :
          (f3 == 3'b000 && st == 6 && f7) ? 3'b001 : 3'b000;
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
    case (st)
      0:  begin irw = 1; sb = 2; rs = 2; pcw = 1; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = dec; end
      7:  begin sa = 2; sb = 1; alu = dec; end
      8:  rw = 1;
      9:  begin sa = 2; alu = 3'b001; pcw = z; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw};
  endfunction

  // One cycle: drive Zero (zmode<0 means random), check at the falling edge, advance.
  task automatic step(input int st, input int zmode);
    Zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
    @(negedge clk);
    check("state", 32'(dbg_state), 32'(st));
    check("outputs", 32'({PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                          ALUControl, ImmSrc, RegWrite}),
          32'(exp_out(st, op, funct3, funct7b5, Zero)));
    check("exclusive", 32'($countones({MemWrite, RegWrite, IRWrite}) <= 1), 32'd1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    check("illegal", 32'(illegal), 32'(st == 11));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    op = o; funct3 = f3; funct7b5 = f7;
    build_path(o);
    foreach (path_q[i]) step(path_q[i], zmode);
  endtask

  logic [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b1111111};

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_irwrite", 32'(IRWrite), 32'd1);
    check("reset_pcwrite", 32'(PCWrite), 32'd1);
    check("reset_regwrite", 32'(RegWrite), 32'd0);
    check("reset_memwrite", 32'(MemWrite), 32'd0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    check("reset_illegal", 32'(illegal), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(7'b0000011, 3'b010, 1'b0, -1);
    run_instr(7'b0110011, 3'b000, 1'b1, -1);
    run_instr(7'b0010011, 3'b000, 1'b1, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1);
    run_instr(7'b1100011, 3'b000, 1'b0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, -1);

    // Reset while a store is in MEMWRITE must abort it cleanly.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    step(0, -1); step(1, -1); step(2, -1);
    @(negedge clk);
    check("sw_memwrite", 32'({dbg_state, MemWrite}), 32'({4'd5, 1'b1}));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      int k;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      k = int'($urandom_range(0, 5));
`else
      k = int'($urandom_range(0, 6));
`endif
      run_instr(ops[k], 3'($urandom), 1'($urandom), -1);
    end

    run_instr(7'b1111111, 3'b000, 1'b0, -1);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    repeat (4) step(11, -1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(7'b0010011, 3'b111, 1'b0, -1);
`else
    run_instr(7'b0100011, 3'b010, 1'b0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
